// File: rtl/fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_scheduler
// Description : Round-robin scheduler that shares one floating-point adder
//               among N_REQ requesters. It latches the winning operands,
//               pulses start, waits for the done rising edge (with a
//               watchdog) and returns the result to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_scheduler #(
    parameter int N_REQ   = 4,
    parameter int PTR_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester side
    input  logic [N_REQ-1:0]      req,
    input  logic [33*N_REQ-1:0]   req_op_a,
    input  logic [33*N_REQ-1:0]   req_op_b,
    input  logic [N_REQ-1:0]      req_operator,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic                  rsp_err,
    output logic                  rsp_s,
    output logic [7:0]            rsp_exp,
    output logic [23:0]           rsp_mant,
    // adder side
    output logic                  parin_s_A,
    output logic [7:0]            parin_exp_A,
    output logic [23:0]           parin_mant_A,
    output logic                  parin_s_B,
    output logic [7:0]            parin_exp_B,
    output logic [23:0]           parin_mant_B,
    output logic                  operator,
    output logic                  start,
    input  logic                  done,
    input  logic                  s_outR,
    input  logic [7:0]            exp_outR,
    input  logic [23:0]           mant_outR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [15:0]      C_TIMEOUT = 16'(TIMEOUT);
    localparam logic [PTR_W-1:0] C_LAST    = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   C_NREQ    = (PTR_W+1)'(N_REQ);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               done_q;
    logic [32:0]        op_a_q, op_a_d;
    logic [32:0]        op_b_q, op_b_d;
    logic               oper_q, oper_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               start_q, start_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [32:0]        res_q, res_d;       // result pending delivery
    logic               res_err_q, res_err_d;
    logic [32:0]        rsp_q, rsp_d;       // result presented to requesters
    logic               rsp_err_q, rsp_err_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     w_sum;

    // Round-robin search: first set req bit starting at ptr, wrapping modulo N_REQ.
    // The loop runs from the farthest slot down so the closest one wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        w_sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (w_sum >= C_NREQ) begin
                w_sum = w_sum - C_NREQ;
            end
            if (req[w_sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = w_sum[PTR_W-1:0];
            end
        end
    end

    // Controller next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        oper_d      = oper_q;
        res_d       = res_q;
        res_err_d   = res_err_q;
        rsp_d       = rsp_q;
        rsp_err_d   = rsp_err_q;
        gnt_d       = '0;
        start_d     = 1'b0;
        rsp_valid_d = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    op_a_d  = req_op_a[33*win_idx +: 33];
                    op_b_d  = req_op_b[33*win_idx +: 33];
                    oper_d  = req_operator[win_idx];
                    owner_d = win_idx;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Only a fresh rising edge of done counts; a level left high
                // from an earlier operation is ignored.
                if (done && !done_q) begin
                    res_d     = {s_outR, exp_outR, mant_outR};
                    res_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == C_TIMEOUT) begin
                    res_d     = '0;
                    res_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                rsp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
                rsp_d       = res_q;
                rsp_err_d   = res_err_q;
                ptr_d       = (owner_q == C_LAST) ? '0 : owner_q + 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            oper_q      <= 1'b0;
            gnt_q       <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            res_q       <= '0;
            res_err_q   <= 1'b0;
            rsp_q       <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            done_q      <= done;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            oper_q      <= oper_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            res_q       <= res_d;
            res_err_q   <= res_err_d;
            rsp_q       <= rsp_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_s        = rsp_q[32];
    assign rsp_exp      = rsp_q[31:24];
    assign rsp_mant     = rsp_q[23:0];
    assign parin_s_A    = op_a_q[32];
    assign parin_exp_A  = op_a_q[31:24];
    assign parin_mant_A = op_a_q[23:0];
    assign parin_s_B    = op_b_q[32];
    assign parin_exp_B  = op_b_q[31:24];
    assign parin_mant_B = op_b_q[23:0];
    assign operator     = oper_q;
    assign start        = start_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_scheduler
// Description : Directed bench for fp_add_scheduler acting as the adder and
//               the requesters (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [131:0] req_op_a, req_op_b;
    logic [3:0]   req_operator;
    logic [3:0]   gnt, rsp_valid;
    logic         rsp_err, rsp_s;
    logic [7:0]   rsp_exp;
    logic [23:0]  rsp_mant;
    logic         parin_s_A, parin_s_B, operator, start;
    logic [7:0]   parin_exp_A, parin_exp_B;
    logic [23:0]  parin_mant_A, parin_mant_B;
    logic         done, s_outR;
    logic [7:0]   exp_outR;
    logic [23:0]  mant_outR;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          slot;
        logic [32:0] a;
        logic [32:0] b;
        logic        opr;
        logic [32:0] res;
    } vec_t;

    vec_t        vecs[4];
    logic [3:0]  g;
    int          n;
    logic [3:0]  anyv;

    fp_add_scheduler #(.N_REQ(4), .PTR_W(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_op_a(req_op_a), .req_op_b(req_op_b), .req_operator(req_operator),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_s(rsp_s), .rsp_exp(rsp_exp), .rsp_mant(rsp_mant),
        .parin_s_A(parin_s_A), .parin_exp_A(parin_exp_A), .parin_mant_A(parin_mant_A),
        .parin_s_B(parin_s_B), .parin_exp_B(parin_exp_B), .parin_mant_B(parin_mant_B),
        .operator(operator), .start(start), .done(done),
        .s_outR(s_outR), .exp_outR(exp_outR), .mant_outR(mant_outR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] oh(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    // One clock; whenever a grant or response is visible they must not overlap.
    task automatic tick();
        @(negedge clk);
        if (!rst && (gnt != 4'b0 || rsp_valid != 4'b0))
            chk("gnt_rsp_overlap", 64'(gnt & rsp_valid), 64'd0);
    endtask

    task automatic wait_gnt(output logic [3:0] gg, output int nn);
        nn = 0;
        while (nn < 40 && gnt == 4'b0) begin
            tick();
            nn++;
        end
        gg = gnt;
        if (gnt == 4'b0) chk("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_ops(input int s, input logic [32:0] a, input logic [32:0] b, input logic o);
        req_op_a[33*s +: 33] = a;
        req_op_b[33*s +: 33] = b;
        req_operator[s]      = o;
    endtask

    // Raise done with a result, then expect the response two cycles later.
    task automatic finish_op(input int s, input logic [32:0] res);
        {s_outR, exp_outR, mant_outR} = res;
        done = 1'b1;
        tick();
        chk("early_rsp", 64'(rsp_valid), 64'd0);
        done = 1'b0;
        tick();
        chk("rsp_valid", 64'(rsp_valid), 64'(oh(s)));
        chk("rsp_err", 64'(rsp_err), 64'd0);
        chk("rsp_data", 64'({rsp_s, rsp_exp, rsp_mant}), 64'(res));
    endtask

    // Called on the cycle gnt is seen: start must follow one cycle later.
    task automatic serve(input int s, input logic [32:0] res);
        tick();
        chk("start", 64'(start), 64'd1);
        chk("gnt_pulse", 64'(gnt), 64'd0);
        finish_op(s, res);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{0, {1'b0, 8'h01, 24'h800000}, {1'b0, 8'h01, 24'h800000}, 1'b0, {1'b0, 8'h02, 24'h800000}};
        vecs[1] = '{1, {1'b0, 8'h7F, 24'h800000}, {1'b0, 8'h80, 24'h800000}, 1'b0, {1'b0, 8'h80, 24'hC00000}};
        vecs[2] = '{2, {1'b0, 8'h80, 24'hC00000}, {1'b0, 8'h7F, 24'h800000}, 1'b1, {1'b0, 8'h80, 24'h800000}};
        vecs[3] = '{3, {1'b1, 8'h7F, 24'h800000}, {1'b1, 8'h7F, 24'h800000}, 1'b0, {1'b1, 8'h80, 24'h800000}};

        rst = 1'b1; req = '0; done = 1'b0;
        s_outR = 1'b0; exp_outR = '0; mant_outR = '0;
        for (int s = 0; s < 4; s++)
            set_ops(s, {1'b1, 8'(8'h10 + s), 24'(24'hA00000 + s)},
                       {1'b0, 8'(8'h20 + s), 24'(24'h500000 + s)}, 1'b1);
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'({gnt, rsp_valid, rsp_err, start, operator}), 64'd0);
        chk("reset_rsp", 64'({rsp_s, rsp_exp, rsp_mant}), 64'd0);
        chk("reset_parin", {parin_s_A, parin_exp_A, parin_mant_A, parin_s_B, parin_exp_B, parin_mant_B}, 64'd0);
        rst = 1'b0;
        tick();

        // Table: one requester at a time, each slot once.
        for (int i = 0; i < 4; i++) begin
            req_operator = {4{~vecs[i].opr}};
            set_ops(vecs[i].slot, vecs[i].a, vecs[i].b, vecs[i].opr);
            req = oh(vecs[i].slot);
            wait_gnt(g, n);
            chk("tbl_gnt", 64'(g), 64'(oh(vecs[i].slot)));
            chk("tbl_gnt_lat", 64'(n), 64'd1);
            chk("tbl_parin_a", 64'({parin_s_A, parin_exp_A, parin_mant_A}), 64'(vecs[i].a));
            chk("tbl_parin_b", 64'({parin_s_B, parin_exp_B, parin_mant_B}), 64'(vecs[i].b));
            chk("tbl_operator", 64'(operator), 64'(vecs[i].opr));
            req = '0;
            serve(vecs[i].slot, vecs[i].res);
        end

        // All four held: round-robin 0,1,2,3,0, back to back.
        req = 4'b1111;
        for (int e = 0; e < 5; e++) begin
            wait_gnt(g, n);
            chk("rr_gnt", 64'(g), 64'(oh(e % 4)));
            chk("rr_lat", 64'(n), 64'd1);
            if (e == 4) req = '0;
            serve(e % 4, {1'b0, 8'(8'h40 + e), 24'(24'h800000 + e)});
        end

        // done held high across START/WAIT: only a re-rise completes.
        req = 4'b0010;
        wait_gnt(g, n);
        chk("hold_gnt", 64'(g), 64'b0010);
        req = '0;
        done = 1'b1;
        tick();
        chk("hold_start", 64'(start), 64'd1);
        anyv = '0;
        repeat (5) begin
            tick();
            anyv |= rsp_valid;
        end
        chk("hold_no_rsp", 64'(anyv), 64'd0);
        done = 1'b0;
        tick();
        chk("hold_low_no_rsp", 64'(rsp_valid), 64'd0);
        finish_op(1, {1'b0, 8'h55, 24'hABCDEF});

        // Reset during WAIT (ptr is 2 here): outputs clear at once, ptr back to 0.
        req = 4'b0010;
        wait_gnt(g, n);
        req = '0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", 64'({gnt, rsp_valid, rsp_err, start, operator}), 64'd0);
        chk("arst_rsp", 64'({rsp_s, rsp_exp, rsp_mant}), 64'd0);
        chk("arst_parin", {parin_s_A, parin_exp_A, parin_mant_A, parin_s_B, parin_exp_B, parin_mant_B}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        anyv = '0;
        repeat (12) begin
            tick();
            anyv |= rsp_valid;
        end
        chk("arst_no_rsp", 64'(anyv), 64'd0);
        req = 4'b0101;
        wait_gnt(g, n);
        chk("arst_ptr0", 64'(g), 64'b0001);
        req = 4'b0100;
        serve(0, {1'b0, 8'h11, 24'h800001});
        wait_gnt(g, n);
        chk("arst_gnt2", 64'(g), 64'b0100);
        req = '0;
        serve(2, {1'b0, 8'h12, 24'h800002});

        // Watchdog on slot 3 with req[0]/req[2] pending.
        req = 4'b1000;
        wait_gnt(g, n);
        chk("to_gnt", 64'(g), 64'b1000);
        req = 4'b0101;
        tick();
        chk("to_start", 64'(start), 64'd1);
        n = 0;
        while (n < 40 && rsp_valid == 4'b0) begin
            tick();
            n++;
        end
        chk("to_latency", 64'(n), 64'd10);
        chk("to_rsp_valid", 64'(rsp_valid), 64'b1000);
        chk("to_rsp_err", 64'(rsp_err), 64'd1);
        chk("to_rsp_zero", 64'({rsp_s, rsp_exp, rsp_mant}), 64'd0);
        wait_gnt(g, n);
        chk("to_wrap_gnt", 64'(g), 64'b0001);
        chk("to_err_held", 64'(rsp_err), 64'd1);
        req = 4'b0100;
        serve(0, {1'b1, 8'h21, 24'h900000});
        wait_gnt(g, n);
        chk("to_next_gnt", 64'(g), 64'b0100);
        req = '0;
        serve(2, {1'b0, 8'h22, 24'hA00000});

        // Owner 3 completes normally with req[0]/req[2] pending: wraps to 0.
        req = 4'b1000;
        wait_gnt(g, n);
        chk("wrap_gnt3", 64'(g), 64'b1000);
        req = 4'b0101;
        serve(3, {1'b0, 8'h33, 24'hC00003});
        wait_gnt(g, n);
        chk("wrap_gnt0", 64'(g), 64'b0001);
        req = 4'b0100;
        serve(0, {1'b0, 8'h30, 24'hC00000});
        wait_gnt(g, n);
        chk("wrap_gnt2", 64'(g), 64'b0100);
        req = '0;
        serve(2, {1'b1, 8'h32, 24'hC00002});

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
